prog_stream_loader: RTL and testbench
=====================================

// Module: prog_stream_loader
// PURPOSE
//  Byte-stream program loader upstream of the core's instruction and data memories.
//  - Consumes a framed byte stream over valid/ready.
//  - Assembles 128-bit instruction lines (4 insns) and 32-bit data words.
//  - Emits memory write strobes while the core is held off.
//  - Raises a sticky done when the stream is consumed; top-level logic uses it to end prog_loading.
// PARAMETERS
//  ADDR_LEN    32      width of addr output (byte address)
//  IMEM_BYTES  8192    instruction memory capacity in bytes (512 lines x 16 B)
//  DMEM_BYTES  8192    data memory capacity in bytes
//  DMEM_BASE   0       byte address of first data word written
// PORTS
//  clk        in   1         single clock, rising edge
//  reset_x    in   1         asynchronous reset, active-low
//  in_valid   in   1         stream byte valid
//  in_data    in   8         stream byte
//  in_ready   out  1         loader accepts byte (transfer when in_valid & in_ready)
//  addr       out  ADDR_LEN  byte address of current write
//  data       out  128       write data; dmem word in data[127:96]
//  we_128     out  1         instruction line write strobe (1 cycle)
//  we_32      out  1         data word write strobe (1 cycle)
//  busy       out  1         high from reset release until done
//  done       out  1         sticky load-complete flag
// BEHAVIOUR
//  Reset (reset_x=0, async):
//  - All outputs 0 except busy=1. State=HDR, all counters and assembly registers cleared.
//  Frame format:
//  - 4 B NI (little-endian), 4 B ND (little-endian), NI insn bytes, ND data bytes.
//  FSM: HDR -> IMEM -> IFLUSH -> DMEM -> DFLUSH -> DONE.
//  - HDR: in_ready=1. Captures 8 header bytes.
//    - After the 8th byte: go to IMEM if NI!=0, else DMEM if ND!=0, else DONE.
//  - IMEM: in_ready=1. Byte k of a line goes to line[127-8*(k^3) -: 8]:
//    - Insn word 0 lands at [127:96], each word little-endian.
//    - On the 16th byte of a line, the line is copied to data.
//    - Next cycle: we_128=1, addr = line index * 16 (first line at 0).
//    - Line index increments after each strobe.
//    - After NI bytes: go to IFLUSH if a partial line is pending, else to DMEM/DONE.
//  - IFLUSH: in_ready=0. Writes the partial line, unfilled bytes zero, one cycle. Then DMEM (ND!=0) or DONE.
//  - DMEM: in_ready=1. 4 bytes form a little-endian word placed in data[127:96]; data[95:0]=0.
//    - Next cycle: we_32=1, addr = DMEM_BASE + 4*word index.
//  - DFLUSH: in_ready=0. Zero-padded partial word written in one cycle. Then DONE.
//  - DONE: in_ready=0, done=1, busy=0. Holds until reset.
//  Write strobes:
//  - Registered, exactly 1 cycle wide, latency 1 cycle after the completing byte.
//  - addr/data stable during the strobe and held until the next strobe.
//  - A byte may be accepted in the same cycle as a strobe; the assembly register is separate from data.
//  - we_128 and we_32 are never high together.
//  Capacity:
//  - Insn bytes at offsets >= IMEM_BYTES and data bytes at offsets >= DMEM_BYTES are consumed but produce no strobe.
//  - Counters saturate; no address wrap.
//  in_valid=0 stalls the FSM with no state change. Counters are 32-bit.
//  reset_x asserted mid-load:
//  - Aborts immediately; partial line/word is discarded.
//  - Restarts at HDR on release.
// TESTING
//  - Reset: reset_x=0 for any cycle -> in_ready=0, we_*=0, done=0, busy=1. Release -> in_ready=1.
//  - NI=32, ND=0, bytes 00..1F:
//    -> we_128 at addr 0, data=0x03020100_07060504_0B0A0908_0F0E0D0C.
//    -> second line at addr 0x10, then done=1.
//  - NI=6, ND=5, DMEM_BASE=0x100:
//    -> one padded line, bytes 4,5 in word 1, rest zero.
//    -> we_32 at 0x100, then we_32 at 0x104 with data[127:96]=0x000000xx.
//    -> then done.
//  - NI=0, ND=0 -> done one cycle after the 8th header byte, no strobes.
//  - Random in_valid gaps (50%) on the 32-byte image -> identical strobe sequence; in_ready never high in flush/DONE.
//  - reset_x low after 10 insn bytes, then a full reload of the NI=32 image -> only the new strobes appear, first at addr 0.

Source files
------------

// File: rtl/prog_stream_loader_if.sv
// Bundle of stream-in handshake, memory-write bus and status signals of the program loader.
// Stream handshake: a byte moves on a rising clk edge where in_valid && in_ready are both high;
// the source holds in_data stable while in_valid is high, and in_ready never depends on in_valid.
interface prog_stream_loader_if #(
  parameter int unsigned ADDR_LEN = 32
);
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic [ADDR_LEN-1:0] addr;
  logic [127:0]        data;
  logic                we_128;
  logic                we_32;
  logic                busy;
  logic                done;
  logic [2:0]          dbg_state;

  // master: byte source / memory side, slave: the loader
  modport master (
    output in_valid, in_data,
    input  in_ready, addr, data, we_128, we_32, busy, done, dbg_state
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, addr, data, we_128, we_32, busy, done, dbg_state
  );
endinterface

// File: rtl/prog_stream_loader.sv
// Program loader: parses an NI/ND framed byte stream into 128-bit imem line writes and
// 32-bit dmem word writes, then raises a sticky done.
module prog_stream_loader #(
  parameter int unsigned ADDR_LEN   = 32,
  parameter int unsigned IMEM_BYTES = 8192,
  parameter int unsigned DMEM_BYTES = 8192,
  parameter int unsigned DMEM_BASE  = 0
) (
  input logic                 clk,
  input logic                 reset_x,
  prog_stream_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_IMEM   = 3'd1,
    S_IFLUSH = 3'd2,
    S_DMEM   = 3'd3,
    S_DFLUSH = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [31:0] IMEM_LIM = 32'(IMEM_BYTES);
  localparam logic [31:0] DMEM_LIM = 32'(DMEM_BYTES);
  localparam logic [31:0] DBASE    = 32'(DMEM_BASE);

  state_e              state_q, state_d;
  logic                run_q;
  logic [2:0]          hcnt_q, hcnt_d;
  logic [31:0]         ni_q, ni_d, nd_q, nd_d;
  logic [31:0]         ib_q, ib_d, db_q, db_d;
  logic [127:0]        line_q, line_d, line_ins;
  logic [31:0]         word_q, word_d, word_ins;
  logic [127:0]        data_q, data_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic                we128_q, we128_d, we32_q, we32_d;
  logic                in_ready, accept;
  logic [31:0]         iline_base, dword_base;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // run_q keeps in_ready low while reset is held and for the release cycle
  assign in_ready   = run_q && (state_q == S_HDR || state_q == S_IMEM || state_q == S_DMEM);
  assign accept     = bus.in_valid && in_ready;
  assign iline_base = {ib_q[31:4], 4'b0000};
  assign dword_base = {db_q[31:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    ni_d     = ni_q;
    nd_d     = nd_q;
    ib_d     = ib_q;
    db_d     = db_q;
    line_d   = line_q;
    word_d   = word_q;
    data_d   = data_q;
    addr_d   = addr_q;
    we128_d  = 1'b0;
    we32_d   = 1'b0;
    line_ins = line_q;
    word_ins = word_q;
    // Byte k of a line: insn words big-endian across the line, bytes little-endian within a word
    for (int b = 0; b < 16; b++) begin
      if (ib_q[3:0] == 4'(b)) line_ins[127-8*(b^3) -: 8] = bus.in_data;
    end
    word_ins[8*db_q[1:0] +: 8] = bus.in_data;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (!hcnt_q[2]) ni_d[8*hcnt_q[1:0] +: 8] = bus.in_data;
          else            nd_d[8*hcnt_q[1:0] +: 8] = bus.in_data;
          hcnt_d = hcnt_q + 3'd1;
          if (hcnt_q == 3'd7) begin
            if (ni_q != 32'd0)      state_d = S_IMEM;
            else if (nd_d != 32'd0) state_d = S_DMEM;
            else                    state_d = S_DONE;
          end
        end
      end
      S_IMEM: begin
        if (accept) begin
          ib_d = sat_inc(ib_q);
          if (ib_q[3:0] == 4'hF) begin
            line_d = '0;
            if (iline_base < IMEM_LIM) begin
              we128_d = 1'b1;
              data_d  = line_ins;
              addr_d  = ADDR_LEN'(iline_base);
            end
          end else begin
            line_d = line_ins;
          end
          if (ib_d == ni_q) begin
            if (ib_q[3:0] != 4'hF)  state_d = S_IFLUSH;
            else if (nd_q != 32'd0) state_d = S_DMEM;
            else                    state_d = S_DONE;
          end
        end
      end
      S_IFLUSH: begin
        line_d = '0;
        if (iline_base < IMEM_LIM) begin
          we128_d = 1'b1;
          data_d  = line_q;
          addr_d  = ADDR_LEN'(iline_base);
        end
        state_d = (nd_q != 32'd0) ? S_DMEM : S_DONE;
      end
      S_DMEM: begin
        if (accept) begin
          db_d = sat_inc(db_q);
          if (db_q[1:0] == 2'd3) begin
            word_d = '0;
            if (dword_base < DMEM_LIM) begin
              we32_d = 1'b1;
              data_d = {word_ins, 96'd0};
              addr_d = ADDR_LEN'(DBASE + dword_base);
            end
          end else begin
            word_d = word_ins;
          end
          if (db_d == nd_q) state_d = (db_q[1:0] != 2'd3) ? S_DFLUSH : S_DONE;
        end
      end
      S_DFLUSH: begin
        word_d = '0;
        if (dword_base < DMEM_LIM) begin
          we32_d = 1'b1;
          data_d = {word_q, 96'd0};
          addr_d = ADDR_LEN'(DBASE + dword_base);
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= S_HDR;
      run_q   <= 1'b0;
      hcnt_q  <= '0;
      ni_q    <= '0;
      nd_q    <= '0;
      ib_q    <= '0;
      db_q    <= '0;
      line_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      we128_q <= 1'b0;
      we32_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      hcnt_q  <= hcnt_d;
      ni_q    <= ni_d;
      nd_q    <= nd_d;
      ib_q    <= ib_d;
      db_q    <= db_d;
      line_q  <= line_d;
      word_q  <= word_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we128_q <= we128_d;
      we32_q  <= we32_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.addr      = addr_q;
  assign bus.data      = data_q;
  assign bus.we_128    = we128_q;
  assign bus.we_32     = we32_q;
  assign bus.busy      = (state_q != S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_prog_stream_loader.sv
// Directed bench for prog_stream_loader: framed images in, strobe sequence checked against hand-computed values.
module tb_prog_stream_loader;
  localparam int W = 161;  // {is_word32, addr[31:0], data[127:0]}

  localparam logic [127:0] L00 = 128'h03020100_07060504_0B0A0908_0F0E0D0C;
  localparam logic [127:0] L10 = 128'h13121110_17161514_1B1A1918_1F1E1D1C;
  localparam logic [127:0] L40 = 128'h43424140_47464544_4B4A4948_4F4E4D4C;
  localparam logic [127:0] L50 = 128'h53525150_57565554_5B5A5958_5F5E5D5C;
  localparam logic [127:0] LA0 = 128'hA3A2A1A0_0000A5A4_00000000_00000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_x = 1'b0;
  always #5 clk = ~clk;

  prog_stream_loader_if #(.ADDR_LEN(32)) ifc ();

  prog_stream_loader #(
    .ADDR_LEN(32), .IMEM_BYTES(32), .DMEM_BYTES(8), .DMEM_BASE(32'h100)
  ) dut (
    .clk(clk), .reset_x(reset_x), .bus(ifc)
  );

  int checks = 0;
  int failures = 0;
  int excl_viol = 0;
  int rdy_viol = 0;
  bit gaps = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_x) begin
      if (ifc.we_128) got_q.push_back({1'b0, ifc.addr, ifc.data});
      if (ifc.we_32)  got_q.push_back({1'b1, ifc.addr, ifc.data});
      if (ifc.we_128 && ifc.we_32) excl_viol++;
      if (ifc.in_ready && (ifc.dbg_state == 3'd2 || ifc.dbg_state == 3'd4 || ifc.dbg_state == 3'd5))
        rdy_viol++;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps) begin
      n = 0;
      while ($urandom_range(0, 1) == 1 && n < 8) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    n = 0;
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 0, 1);
    else @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] ni, input logic [31:0] nd);
    for (int i = 0; i < 4; i++) send_byte(ni[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(nd[8*i +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_x = 1'b0;
    repeat (2) @(negedge clk);
    reset_x = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!ifc.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, ifc.done, 1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic score(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_nstrobes"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_strobe"}, got_q.pop_front(), exp_q.pop_front());
    check({tag, "_excl"}, excl_viol, 0);
    check({tag, "_rdy_flush"}, rdy_viol, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_image32();
    send_hdr(32, 0);
    for (int i = 0; i < 32; i++) send_byte(8'(i));
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;

    // Reset values while held
    repeat (3) @(negedge clk);
    check("rst_ready", ifc.in_ready, 0);
    check("rst_we128", ifc.we_128, 0);
    check("rst_we32", ifc.we_32, 0);
    check("rst_done", ifc.done, 0);
    check("rst_busy", ifc.busy, 1);
    reset_x = 1'b1;
    @(negedge clk);
    check("rel_ready", ifc.in_ready, 1);

    // NI=32, ND=0 with strobe latency checks
    exp_q.push_back({1'b0, 32'h0, L00});
    exp_q.push_back({1'b0, 32'h10, L10});
    send_hdr(32, 0);
    for (int i = 0; i < 32; i++) begin
      send_byte(8'(i));
      if (i == 15) begin
        @(negedge clk);
        check("t1_lat_we128", ifc.we_128, 1);
        check("t1_lat_addr", ifc.addr, 32'h0);
      end
    end
    @(negedge clk);
    check("t1_lat2_we128", ifc.we_128, 1);
    check("t1_lat2_data", ifc.data, L10);
    check("t1_done", ifc.done, 1);
    check("t1_busy", ifc.busy, 0);
    score("t1");
    check("t1_hold_addr", ifc.addr, 32'h10);

    // NI=6, ND=5: padded line, full word then padded word
    do_reset();
    exp_q.push_back({1'b0, 32'h0, LA0});
    exp_q.push_back({1'b1, 32'h100, {32'hD3D2D1D0, 96'd0}});
    exp_q.push_back({1'b1, 32'h104, {32'h000000D4, 96'd0}});
    send_hdr(6, 5);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) send_byte(8'hD0 + 8'(i));
    wait_done("t2");
    score("t2");

    // NI=0, ND=0: done one cycle after the header
    do_reset();
    send_hdr(0, 0);
    @(negedge clk);
    check("t3_done", ifc.done, 1);
    check("t3_busy", ifc.busy, 0);
    check("t3_ready", ifc.in_ready, 0);
    score("t3");

    // 32-byte image with random valid gaps
    do_reset();
    gaps = 1'b1;
    exp_q.push_back({1'b0, 32'h0, L00});
    exp_q.push_back({1'b0, 32'h10, L10});
    send_image32();
    gaps = 1'b0;
    wait_done("t4");
    score("t4");

    // Reset mid-load after 10 insn bytes, then full reload
    do_reset();
    send_hdr(32, 0);
    for (int i = 0; i < 10; i++) send_byte(8'hE0 + 8'(i));
    @(negedge clk);
    reset_x = 1'b0;
    @(negedge clk);
    check("t5_abort_ready", ifc.in_ready, 0);
    check("t5_abort_busy", ifc.busy, 1);
    check("t5_abort_nstrobes", got_q.size(), 0);
    @(negedge clk);
    reset_x = 1'b1;
    got_q.delete();
    exp_q.push_back({1'b0, 32'h0, L00});
    exp_q.push_back({1'b0, 32'h10, L10});
    send_image32();
    wait_done("t5");
    score("t5");

    // Capacity: 32 B imem and 8 B dmem in this instance; overflow bytes consumed silently
    do_reset();
    exp_q.push_back({1'b0, 32'h0, L40});
    exp_q.push_back({1'b0, 32'h10, L50});
    exp_q.push_back({1'b1, 32'h100, {32'h83828180, 96'd0}});
    exp_q.push_back({1'b1, 32'h104, {32'h87868584, 96'd0}});
    send_hdr(40, 12);
    for (int i = 0; i < 40; i++) send_byte(8'h40 + 8'(i));
    for (int i = 0; i < 12; i++) send_byte(8'h80 + 8'(i));
    wait_done("t6");
    score("t6");
    check("t6_hold_addr", ifc.addr, 32'h104);
    check("t6_hold_data", ifc.data, {32'h87868584, 96'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
